// File: rtl/axi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_pkg
// Purpose  : Shared FSM state, AXI response and burst encodings for the
//            AXI4 SRAM responder.
// Revision : 1.0
// ============================================================================
package axi_sram_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WR_RESP  = 3'd2,
        RD_FETCH = 3'd3,
        RD_DATA  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Encodings are ordered by severity, so the numerically larger one wins.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bytewise.sv
`default_nettype none
// ============================================================================
// Module   : sram_bytewise
// Purpose  : Single-port 64-bit SRAM with per-byte write enables and a
//            registered (1-cycle) read.
// Revision : 1.0
// ============================================================================
module sram_bytewise #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_we,
    input  logic [63:0]   i_wdata,
    input  logic          i_re,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [WORDS];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_responder
// Purpose  : AXI4 subordinate in front of one 64-bit SRAM, one burst in
//            flight. Define AXI_SRAM_WRAP_EN to support WRAP bursts.
// Revision : 1.0
// ============================================================================
module axi_sram_responder
    import axi_sram_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  S_AXI_AWID,
    input  logic [63:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWLOCK,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWQOS,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [3:0]  S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [3:0]  S_AXI_ARID,
    input  logic [63:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARLOCK,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARQOS,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [3:0]  S_AXI_RID,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_id;
    logic [63:0] r_addr;
    logic [7:0]  r_len, r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst, r_bresp, r_rresp;

    logic [63:0] w_off, w_step, w_addr_nxt;
    logic        w_in_range, w_unsup, w_rlast;
    logic [1:0]  w_beat_resp, w_len_resp;
    logic [7:0]  w_beat_nxt;
    logic        w_awready, w_arready, w_wready, w_bvalid, w_rvalid;
    logic        w_aw_hs, w_ar_hs, w_w_hs;
    logic [63:0] w_sram_q;
    logic [7:0]  w_sram_we;
    logic        w_sram_re;
    logic        w_unused;
`ifdef AXI_SRAM_WRAP_EN
    logic [63:0] w_wrap_mask;
`endif

    assign w_off       = r_addr - BASE_ADDR;
    assign w_in_range  = (w_off >> (AW + 3)) == 64'd0;
    assign w_step      = 64'd1 << r_size;
    assign w_beat_nxt  = (r_beat == 8'hFF) ? r_beat : r_beat + 8'd1;
    assign w_rlast     = (r_beat == r_len);
    assign w_len_resp  = (S_AXI_WLAST && !w_rlast) ? RESP_SLVERR : RESP_OKAY;
    assign w_beat_resp = !w_in_range ? RESP_DECERR : (w_unsup ? RESP_SLVERR : RESP_OKAY);

    always_comb begin
        w_unsup = (r_size > 3'd3);
        case (r_burst)
            BURST_FIXED, BURST_INCR: ;
`ifdef AXI_SRAM_WRAP_EN
            BURST_WRAP: if (!(r_len inside {8'd1, 8'd3, 8'd7, 8'd15})) w_unsup = 1'b1;
`endif
            default: w_unsup = 1'b1;
        endcase
    end

    always_comb begin
        w_addr_nxt = r_addr;
`ifdef AXI_SRAM_WRAP_EN
        w_wrap_mask = (({56'd0, r_len} + 64'd1) << r_size) - 64'd1;
`endif
        case (r_burst)
            BURST_INCR: w_addr_nxt = r_addr + w_step;
`ifdef AXI_SRAM_WRAP_EN
            BURST_WRAP: w_addr_nxt = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
`endif
            default: ;
        endcase
    end

    // Handshake qualifiers are gated by reset so nothing is accepted while rst_i is high.
    always_comb begin
        w_state_nxt = r_state;
        w_awready   = 1'b0;
        w_arready   = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        w_rvalid    = 1'b0;
        case (r_state)
            IDLE: begin
                w_awready = !rst_i && S_AXI_AWVALID;
                w_arready = !rst_i && S_AXI_ARVALID && !S_AXI_AWVALID;
                if (w_awready)      w_state_nxt = WR_DATA;
                else if (w_arready) w_state_nxt = RD_FETCH;
            end
            WR_DATA: begin
                w_wready = !rst_i;
                if (S_AXI_WVALID && S_AXI_WLAST) w_state_nxt = WR_RESP;
            end
            WR_RESP: begin
                w_bvalid = !rst_i;
                if (S_AXI_BREADY) w_state_nxt = IDLE;
            end
            RD_FETCH: w_state_nxt = RD_DATA;
            RD_DATA: begin
                w_rvalid = !rst_i;
                if (S_AXI_RREADY) w_state_nxt = w_rlast ? IDLE : RD_FETCH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_aw_hs = w_awready;
    assign w_ar_hs = w_arready;
    assign w_w_hs  = w_wready && S_AXI_WVALID;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_id    <= 4'd0;
            r_addr  <= 64'd0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= 2'd0;
            r_bresp <= RESP_OKAY;
            r_rresp <= RESP_OKAY;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_id    <= S_AXI_AWID;
                r_addr  <= S_AXI_AWADDR;
                r_len   <= S_AXI_AWLEN;
                r_size  <= S_AXI_AWSIZE;
                r_burst <= S_AXI_AWBURST;
                r_beat  <= 8'd0;
                r_bresp <= RESP_OKAY;
            end else if (w_ar_hs) begin
                r_id    <= S_AXI_ARID;
                r_addr  <= S_AXI_ARADDR;
                r_len   <= S_AXI_ARLEN;
                r_size  <= S_AXI_ARSIZE;
                r_burst <= S_AXI_ARBURST;
                r_beat  <= 8'd0;
            end
            if (w_w_hs) begin
                r_addr  <= w_addr_nxt;
                r_beat  <= w_beat_nxt;
                r_bresp <= resp_worst(r_bresp, resp_worst(w_beat_resp, w_len_resp));
            end
            if (r_state == RD_FETCH) begin
                r_rresp <= w_beat_resp;
            end
            if (w_rvalid && S_AXI_RREADY && !w_rlast) begin
                r_addr <= w_addr_nxt;
                r_beat <= w_beat_nxt;
            end
        end
    end

    assign w_sram_we = (w_w_hs && w_beat_resp == RESP_OKAY) ? S_AXI_WSTRB : 8'h00;
    assign w_sram_re = (r_state == RD_FETCH) && (w_beat_resp == RESP_OKAY);

    sram_bytewise #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk     (clk_i),
        .i_addr  (w_off[AW+2:3]),
        .i_we    (w_sram_we),
        .i_wdata (S_AXI_WDATA),
        .i_re    (w_sram_re),
        .o_rdata (w_sram_q)
    );

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BID     = w_bvalid ? r_id : 4'd0;
    assign S_AXI_BRESP   = w_bvalid ? r_bresp : RESP_OKAY;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RID     = w_rvalid ? r_id : 4'd0;
    assign S_AXI_RRESP   = w_rvalid ? r_rresp : RESP_OKAY;
    assign S_AXI_RLAST   = w_rvalid && w_rlast;
    assign S_AXI_RDATA   = (w_rvalid && r_rresp == RESP_OKAY) ? w_sram_q : 64'd0;

    assign w_unused = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                        S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, w_off[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_responder
// Purpose  : Directed, scoreboard-checked bench for axi_sram_responder.
//            Expectations follow AXI_SRAM_WRAP_EN when it is defined.
// Revision : 1.0
// ============================================================================
module tb_axi_sram_responder;

    localparam int          MEM_WORDS = 1024;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          BUDGET    = 100;
`ifdef AXI_SRAM_WRAP_EN
    localparam bit          WRAP_EN   = 1'b1;
`else
    localparam bit          WRAP_EN   = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  S_AXI_AWID = '0, S_AXI_ARID = '0;
    logic [63:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_AWSIZE = 3'd3, S_AXI_ARSIZE = 3'd3;
    logic [1:0]  S_AXI_AWBURST = 2'b01, S_AXI_ARBURST = 2'b01;
    logic        S_AXI_AWLOCK = 1'b1, S_AXI_ARLOCK = 1'b1;
    logic [3:0]  S_AXI_AWCACHE = 4'hF, S_AXI_ARCACHE = 4'hF;
    logic [2:0]  S_AXI_AWPROT = 3'h7, S_AXI_ARPROT = 3'h7;
    logic [3:0]  S_AXI_AWQOS = 4'hA, S_AXI_ARQOS = 4'hA;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic        S_AXI_AWREADY, S_AXI_ARREADY;
    logic [63:0] S_AXI_WDATA = '0;
    logic [7:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_WREADY;
    logic [3:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_RID;
    logic [63:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY = 1'b0;

    always #5 clk_i = ~clk_i;

    axi_sram_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
        .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWQOS(S_AXI_AWQOS),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
        .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARQOS(S_AXI_ARQOS),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [63:0] mdl [MEM_WORDS];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int i,
                                              input logic [1:0] burst, input logic [7:0] len);
        logic [63:0] bnd, lo;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            bnd = (64'(len) + 64'd1) * 64'd8;
            lo  = a % bnd;
            return a - lo + ((lo + 64'(i) * 64'd8) % bnd);
        end
        return a + 64'(i) * 64'd8;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [63:0] a, input logic [1:0] burst,
                                             input logic [7:0] len);
        bit wrap_ok;
        wrap_ok = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        if (a < BASE || (a - BASE) >= 64'(MEM_WORDS) * 64'd8) return 2'b11;
        if (burst == 2'b00 || burst == 2'b01 || (burst == 2'b10 && wrap_ok)) return 2'b00;
        return 2'b10;
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n;
        n = 0;
        @(negedge clk_i);
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        #1;
        while (!S_AXI_AWREADY && n < BUDGET) begin @(negedge clk_i); #1; n++; end
        chk("aw_accept", S_AXI_AWREADY, 1'b1);
        @(posedge clk_i);
        #1 S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n;
        n = 0;
        @(negedge clk_i);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        #1;
        while (!S_AXI_ARREADY && n < BUDGET) begin @(negedge clk_i); #1; n++; end
        chk("ar_accept", S_AXI_ARREADY, 1'b1);
        @(posedge clk_i);
        #1 S_AXI_ARVALID = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n;
        n = 0;
        @(negedge clk_i);
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
        #1;
        while (!S_AXI_WREADY && n < BUDGET) begin @(negedge clk_i); #1; n++; end
        chk("w_accept", S_AXI_WREADY, 1'b1);
        @(posedge clk_i);
        #1 S_AXI_WVALID = 1'b0;
    endtask

    task automatic wait_b(input string tag);
        int n;
        b_exp_t e;
        n = 0;
        @(negedge clk_i);
        while (!S_AXI_BVALID && n < BUDGET) begin @(negedge clk_i); n++; end
        chk({tag, "_bvalid"}, S_AXI_BVALID, 1'b1);
        e = b_q.pop_front();
        chk({tag, "_bid"}, S_AXI_BID, e.id);
        chk({tag, "_bresp"}, S_AXI_BRESP, e.resp);
        S_AXI_BREADY = 1'b1;
        @(posedge clk_i);
        #1 S_AXI_BREADY = 1'b0;
    endtask

    task automatic collect_r(input string tag, input int nbeats, input int stall_beat, input int stall_cyc);
        int n;
        r_exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            @(negedge clk_i);
            while (!S_AXI_RVALID && n < BUDGET) begin @(negedge clk_i); n++; end
            chk({tag, "_rvalid"}, S_AXI_RVALID, 1'b1);
            e = r_q.pop_front();
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clk_i);
                    chk({tag, "_stall_hold"}, {S_AXI_RVALID, S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA},
                        {1'b1, e.id, e.last, e.resp, e.data});
                end
            end
            chk({tag, "_rid"}, S_AXI_RID, e.id);
            chk({tag, "_rdata"}, S_AXI_RDATA, e.data);
            chk({tag, "_rresp"}, S_AXI_RRESP, e.resp);
            chk({tag, "_rlast"}, S_AXI_RLAST, e.last);
            S_AXI_RREADY = 1'b1;
            @(posedge clk_i);
            #1 S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic write_burst(input string tag, input logic [3:0] id, input logic [63:0] addr,
                               input logic [7:0] len, input logic [1:0] burst, input int nbeats,
                               input logic [7:0] strb, input logic [31:0] seed);
        logic [1:0]  worst, r;
        logic [63:0] a, d;
        b_exp_t      e;
        worst = 2'b00;
        for (int i = 0; i < nbeats; i++) begin
            r = beat_resp(beat_addr(addr, i, burst, len), burst, len);
            if (r > worst) worst = r;
        end
        if (nbeats - 1 != int'(len) && worst < 2'b10) worst = 2'b10;
        e.id = id; e.resp = worst;
        b_q.push_back(e);
        send_aw(id, addr, len, burst);
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(addr, i, burst, len);
            d = {seed, 32'(i) ^ 32'h0F0F_0000};
            send_w(d, strb, i == nbeats - 1);
            if (beat_resp(a, burst, len) == 2'b00)
                for (int k = 0; k < 8; k++) if (strb[k]) mdl[widx(a)][k*8 +: 8] = d[k*8 +: 8];
        end
        wait_b(tag);
    endtask

    task automatic read_burst(input string tag, input logic [3:0] id, input logic [63:0] addr,
                              input logic [7:0] len, input logic [1:0] burst,
                              input int stall_beat, input int stall_cyc);
        r_exp_t      e;
        logic [63:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a      = beat_addr(addr, i, burst, len);
            e.id   = id;
            e.resp = beat_resp(a, burst, len);
            e.data = (e.resp == 2'b00) ? mdl[widx(a)] : 64'd0;
            e.last = (i == int'(len));
            r_q.push_back(e);
        end
        send_ar(id, addr, len, burst);
        collect_r(tag, int'(len) + 1, stall_beat, stall_cyc);
    endtask

    function automatic logic [81:0] all_outs();
        return {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP,
                S_AXI_RVALID, S_AXI_RID, S_AXI_RRESP, S_AXI_RDATA, S_AXI_RLAST};
    endfunction

    initial begin
        int          n;
        b_exp_t      be;
        r_exp_t      re;
        logic [63:0] d;

        // Reset with requests pending: nothing may be acknowledged.
        S_AXI_AWVALID = 1'b1; S_AXI_ARVALID = 1'b1; S_AXI_WVALID = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            chk("reset_outputs", all_outs(), 82'd0);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_WVALID = 1'b0;
        rst_i = 1'b0;

        write_burst("incr_wr", 4'd5, BASE + 64'h10, 8'd3, 2'b01, 4, 8'hFF, 32'hA000_0001);
        read_burst("incr_rd", 4'd9, BASE + 64'h10, 8'd3, 2'b01, 0, 5);

        // Simultaneous AW/AR: the write wins, the read waits for the B handshake.
        be.id = 4'd3; be.resp = 2'b00;
        b_q.push_back(be);
        @(negedge clk_i);
        S_AXI_AWID = 4'd3; S_AXI_AWADDR = BASE + 64'h40; S_AXI_AWLEN = 8'd0;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        S_AXI_ARID = 4'd4; S_AXI_ARADDR = BASE + 64'h40; S_AXI_ARLEN = 8'd0;
        S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        #1;
        chk("simul_awready", S_AXI_AWREADY, 1'b1);
        chk("simul_arready", S_AXI_ARREADY, 1'b0);
        @(posedge clk_i);
        #1 S_AXI_AWVALID = 1'b0;
        #1 chk("simul_ar_blocked", S_AXI_ARREADY, 1'b0);
        d = 64'hDEAD_BEEF_0000_0040;
        send_w(d, 8'hFF, 1'b1);
        mdl[widx(BASE + 64'h40)] = d;
        wait_b("simul_wr");
        re.id = 4'd4; re.data = d; re.resp = 2'b00; re.last = 1'b1;
        r_q.push_back(re);
        n = 0;
        @(negedge clk_i);
        #1;
        while (!S_AXI_ARREADY && n < BUDGET) begin @(negedge clk_i); #1; n++; end
        chk("simul_ar_after_b", S_AXI_ARREADY, 1'b1);
        @(posedge clk_i);
        #1 S_AXI_ARVALID = 1'b0;
        collect_r("simul_rd", 1, -1, 0);

        read_burst("decerr_rd", 4'd2, BASE + 64'(MEM_WORDS) * 64'd8, 8'd1, 2'b01, -1, 0);

        write_burst("strobe_wr", 4'hA, BASE + 64'h10, 8'd0, 2'b01, 1, 8'h0F, 32'h5555_5555);
        read_burst("strobe_rd", 4'hB, BASE + 64'h10, 8'd0, 2'b01, -1, 0);
        write_burst("early_last", 4'hC, BASE + 64'h200, 8'd3, 2'b01, 2, 8'hFF, 32'h7777_0000);
        write_burst("fixed_wr", 4'hD, BASE + 64'h400, 8'd1, 2'b00, 2, 8'hFF, 32'h6666_0000);
        read_burst("fixed_rd", 4'hE, BASE + 64'h400, 8'd1, 2'b00, -1, 0);

        write_burst("pre_wrap", 4'd1, BASE, 8'd3, 2'b01, 4, 8'hFF, 32'h1111_0000);
        write_burst("wrap_wr", 4'd2, BASE + 64'h18, 8'd3, 2'b10, 4, 8'hFF, 32'h2222_0000);
        read_burst("wrap_land", 4'd3, BASE, 8'd3, 2'b01, -1, 0);
        read_burst("wrap_rd", 4'd4, BASE + 64'h18, 8'd3, 2'b10, -1, 0);

        // Reset during beat 2 of a len-7 write.
        write_burst("pre_rst", 4'd0, BASE + 64'h100, 8'd1, 2'b01, 2, 8'hFF, 32'h3333_0000);
        send_aw(4'd6, BASE + 64'h100, 8'd7, 2'b01);
        d = 64'h4444_0000_0000_0001;
        send_w(d, 8'hFF, 1'b0);
        mdl[widx(BASE + 64'h100)] = d;
        @(negedge clk_i);
        S_AXI_WDATA = 64'h4444_0000_0000_0002; S_AXI_WSTRB = 8'hFF; S_AXI_WLAST = 1'b0;
        S_AXI_WVALID = 1'b1; rst_i = 1'b1;
        #1 chk("midrst_outputs", all_outs(), 82'd0);
        @(posedge clk_i);
        #1 chk("midrst_outputs_edge", all_outs(), 82'd0);
        @(negedge clk_i);
        S_AXI_WVALID = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            chk("midrst_no_b", S_AXI_BVALID, 1'b0);
        end
        write_burst("after_rst", 4'd7, BASE + 64'h300, 8'd0, 2'b01, 1, 8'hFF, 32'h8888_0000);
        read_burst("rst_rd", 4'd8, BASE + 64'h100, 8'd1, 2'b01, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_responder.md
AXI_SRAM_RESPONDER -- requirements
Module: axi_sram_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving the number of 64-bit SRAM words (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 64'h8000_0000, giving the byte address of word 0.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have AW-channel ports S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID as inputs of 4/64/8/3/2/1 bits, and S_AXI_AWREADY as a 1-bit output.
REQ-006 The block SHALL have W-channel ports S_AXI_WDATA/WSTRB/WLAST/WVALID as inputs of 64/8/1/1 bits, and S_AXI_WREADY as a 1-bit output.
REQ-007 The block SHALL have B-channel ports S_AXI_BID/BRESP/BVALID as outputs of 4/2/1 bits, and S_AXI_BREADY as a 1-bit input.
REQ-008 The block SHALL have AR-channel ports S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID as inputs of 4/64/8/3/2/1 bits, and S_AXI_ARREADY as a 1-bit output.
REQ-009 The block SHALL have R-channel ports S_AXI_RID/RDATA/RRESP/RLAST/RVALID as outputs of 4/64/2/1/1 bits, and S_AXI_RREADY as a 1-bit input.
REQ-010 The block SHALL accept AWLOCK/AWCACHE/AWPROT/AWQOS and ARLOCK/ARCACHE/ARPROT/ARQOS as inputs and ignore them.

Function
REQ-011 The block SHALL act as an AXI4 subordinate to one 64-bit SRAM array and have one transaction in flight at a time.
REQ-012 The FSM SHALL have states IDLE, WR_DATA, WR_RESP, RD_FETCH and RD_DATA.
REQ-013 In IDLE, AWREADY SHALL equal AWVALID; ARREADY SHALL equal ARVALID and not AWVALID (write wins a simultaneous request).
REQ-014 An AW handshake SHALL latch id, address, len, size and burst, then move the FSM to WR_DATA.
REQ-015 An AR handshake SHALL latch the same fields, then move the FSM to RD_FETCH.
REQ-016 In WR_DATA, WREADY SHALL be 1 and each W handshake SHALL write the bytes enabled by WSTRB to word (addr-BASE_ADDR)>>3, then advance the address and the beat count.
REQ-017 A W beat carrying WLAST SHALL move the FSM to WR_RESP.
REQ-018 If WLAST arrives at a beat count other than len, the response SHALL be SLVERR (2'b10), and the FSM SHALL still move to WR_RESP at WLAST.
REQ-019 In WR_RESP, BVALID SHALL be 1 with BID set to the latched id, held stable until BREADY, then the FSM SHALL return to IDLE.
REQ-020 RD_FETCH SHALL read the SRAM (1-cycle latency) and move to RD_DATA.
REQ-021 In RD_DATA, RVALID SHALL be 1 with RDATA/RID/RRESP stable, and RLAST SHALL be 1 when beat count equals len.
REQ-022 On an R handshake in RD_DATA, the FSM SHALL return to IDLE after the last beat, otherwise advance the address and go to RD_FETCH (one beat per 2 cycles).
REQ-023 INCR bursts SHALL advance the address by 2^size, FIXED bursts SHALL keep it constant, and the beat counter SHALL be 8 bits and never wrap.
REQ-024 A beat whose word index lies outside 0..MEM_WORDS-1 SHALL get DECERR (2'b11), no write is performed, and RDATA SHALL be 0.
REQ-025 size>3 or an unsupported burst type SHALL get SLVERR for every beat, with no SRAM access.
REQ-026 Within one burst, error precedence SHALL be DECERR > SLVERR > OKAY, and BRESP SHALL report the worst beat.

Reset
REQ-027 While rst_i is high, the FSM SHALL be in IDLE, and all READY and VALID outputs, BID, BRESP, RID, RRESP, RDATA and RLAST SHALL be 0.
REQ-028 A reset mid-burst SHALL abandon the burst, leave SRAM contents unchanged, and issue no B or R response.

Configuration
REQ-029 With AXI_SRAM_WRAP_EN defined, WRAP bursts (len 1, 3, 7, 15) SHALL wrap at boundary (len+1)<<size.
REQ-030 Without AXI_SRAM_WRAP_EN, WRAP bursts SHALL be handled as unsupported, giving SLVERR per REQ-025.

Structure
REQ-031 The FSM state enum, the response constants (OKAY/SLVERR/DECERR) and the burst-encoding constants SHALL live in package axi_sram_pkg.
REQ-032 The SRAM SHALL be a sub-module, sram_bytewise (byte write enables, synchronous read), instantiated once.

Verification
REQ-033 The bench SHALL check: AW addr BASE+0x10, len 3, INCR, 4 beats of WSTRB 8'hFF -> BRESP OKAY, BID matches AWID, words 2..5 written.
REQ-034 The bench SHALL check: AR of the same region, len 3, RREADY held low 5 cycles on beat 1 -> data stable while stalled, RLAST only on beat 4.
REQ-035 The bench SHALL check: AWVALID and ARVALID raised in the same cycle -> AWREADY=1 and ARREADY=0; the read is accepted after BVALID/BREADY.
REQ-036 The bench SHALL check: AR addr BASE+MEM_WORDS*8, len 1 -> 2 beats with RRESP 2'b11 and RDATA 0.
REQ-037 The bench SHALL check: WRAP len 3 at BASE+0x18 -> with macro, beats hit 0x18, 0x00, 0x08, 0x10; without macro, SLVERR.
REQ-038 The bench SHALL check: rst_i pulsed during beat 2 of a len-7 write -> all outputs 0, no BVALID, and the next AW is accepted normally.
